cmos_dvp_pattern_tx: RTL and testbench

Synthesizable DVP-style CMOS sensor emulator: it generates vsync/href/8-bit gray pixel streams with the same framing that the capture path consumes from the MT9V034. It drives the stereo capture, zoom and SGM chain in simulation and on-board bring-up without a physical sensor. It produces deterministic test patterns with programmable active size and blanking, and counts completed frames.

---
 rtl/cmos_dvp_pattern_tx.sv | 164 ++++++++++++++++
 tb/tb_cmos_dvp_pattern_tx.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/cmos_dvp_pattern_tx.sv
// DVP sensor emulator: vsync/href/8-bit gray test patterns with programmable size and blanking.
// Latency: outputs are registered one cycle behind the internal framing FSM.
// No backpressure: free-running pixel stream; enable is honoured only at frame boundaries.
module cmos_dvp_pattern_tx #(
    parameter int IMAGE_HSIZE = 752,
    parameter int IMAGE_VSIZE = 480,
    parameter int H_BLANK     = 94,
    parameter int VSYNC_WIDTH = 16,
    parameter int V_BACK      = 64,
    parameter int V_FRONT     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [1:0] pattern_sel,
    output logic       dvp_vsync,
    output logic       dvp_href,
    output logic [7:0] dvp_data,
    output logic       busy,
    output logic [7:0] frame_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        VSYNC  = 3'd1,
        VBACK  = 3'd2,
        ACTIVE = 3'd3,
        HBLANK = 3'd4,
        VFRONT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] cyc_q, cyc_d;
    logic [15:0] x_q, x_d;
    logic [15:0] y_q, y_d;
    logic [1:0]  pat_q;
    logic [7:0]  f_q;
    logic [7:0]  cnt_q;
    logic        latch_start;
    logic        frame_done;
    logic [7:0]  pix;

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        x_d         = x_q;
        y_d         = y_q;
        latch_start = 1'b0;
        frame_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d     = VSYNC;
                    cyc_d       = 16'd0;
                    latch_start = 1'b1;
                end
            end
            VSYNC: begin
                if (cyc_q == 16'(VSYNC_WIDTH - 1)) begin
                    state_d = VBACK;
                    cyc_d   = 16'd0;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            VBACK: begin
                if (cyc_q == 16'(V_BACK - 1)) begin
                    state_d = ACTIVE;
                    cyc_d   = 16'd0;
                    x_d     = 16'd0;
                    y_d     = 16'd0;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            ACTIVE: begin
                if (x_q == 16'(IMAGE_HSIZE - 1)) begin
                    state_d = (y_q == 16'(IMAGE_VSIZE - 1)) ? VFRONT : HBLANK;
                    cyc_d   = 16'd0;
                end else begin
                    x_d = x_q + 16'd1;
                end
            end
            HBLANK: begin
                if (cyc_q == 16'(H_BLANK - 1)) begin
                    state_d = ACTIVE;
                    cyc_d   = 16'd0;
                    x_d     = 16'd0;
                    y_d     = y_q + 16'd1;
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            VFRONT: begin
                if (cyc_q == 16'(V_FRONT - 1)) begin
                    frame_done = 1'b1;
                    cyc_d      = 16'd0;
                    if (enable) begin
                        state_d     = VSYNC;
                        latch_start = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cyc_d = cyc_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pix = 8'h00;
        case (pat_q)
            2'd0: pix = x_q[7:0];
            2'd1: pix = y_q[7:0];
            2'd2: pix = (x_q[4] ^ y_q[4]) ? 8'hFF : 8'h00;
            2'd3: pix = x_q[7:0] + y_q[7:0] + f_q;
            default: pix = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cyc_q   <= 16'd0;
            x_q     <= 16'd0;
            y_q     <= 16'd0;
            pat_q   <= 2'd0;
            f_q     <= 8'd0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            x_q     <= x_d;
            y_q     <= y_d;
            if (frame_done) begin
                cnt_q <= cnt_q + 8'd1;
            end
            // The next frame's pattern-3 offset must include the count of the frame just closed.
            if (latch_start) begin
                pat_q <= pattern_sel;
                f_q   <= frame_done ? (cnt_q + 8'd1) : cnt_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dvp_vsync <= 1'b0;
            dvp_href  <= 1'b0;
            dvp_data  <= 8'h00;
            busy      <= 1'b0;
            frame_cnt <= 8'd0;
        end else begin
            dvp_vsync <= (state_q == VSYNC);
            dvp_href  <= (state_q == ACTIVE);
            dvp_data  <= (state_q == ACTIVE) ? pix : 8'h00;
            busy      <= (state_q != IDLE);
            frame_cnt <= cnt_q;
        end
    end

endmodule

// File: tb/tb_cmos_dvp_pattern_tx.sv
// Directed bench for cmos_dvp_pattern_tx: small 8x4 instance plus a 32x32 instance for the checker pattern.
module tb_cmos_dvp_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [1:0] pattern_sel;

    logic       vs_a, hr_a, bz_a;
    logic [7:0] dt_a, fc_a;
    logic       vs_b, hr_b, bz_b;
    logic [7:0] dt_b, fc_b;

    logic       sel_b;
    logic       mon_vs, mon_hr, mon_bz;
    logic [7:0] mon_dt, mon_fc;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    cmos_dvp_pattern_tx #(
        .IMAGE_HSIZE(8), .IMAGE_VSIZE(4), .H_BLANK(3),
        .VSYNC_WIDTH(2), .V_BACK(5), .V_FRONT(4)
    ) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .dvp_vsync(vs_a), .dvp_href(hr_a), .dvp_data(dt_a),
        .busy(bz_a), .frame_cnt(fc_a)
    );

    cmos_dvp_pattern_tx #(
        .IMAGE_HSIZE(32), .IMAGE_VSIZE(32), .H_BLANK(3),
        .VSYNC_WIDTH(2), .V_BACK(5), .V_FRONT(4)
    ) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .pattern_sel(pattern_sel),
        .dvp_vsync(vs_b), .dvp_href(hr_b), .dvp_data(dt_b),
        .busy(bz_b), .frame_cnt(fc_b)
    );

    assign mon_vs = sel_b ? vs_b : vs_a;
    assign mon_hr = sel_b ? hr_b : hr_a;
    assign mon_dt = sel_b ? dt_b : dt_a;
    assign mon_bz = sel_b ? bz_b : bz_a;
    assign mon_fc = sel_b ? fc_b : fc_a;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input string tag, input logic [7:0] fc_exp);
        check({tag, "_vsync"}, {31'd0, mon_vs}, 32'd0);
        check({tag, "_href"},  {31'd0, mon_hr}, 32'd0);
        check({tag, "_data"},  {24'd0, mon_dt}, 32'd0);
        check({tag, "_busy"},  {31'd0, mon_bz}, 32'd0);
        check({tag, "_fcnt"},  {24'd0, mon_fc}, {24'd0, fc_exp});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        enable = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    // Start a run and compare every output cycle against a framing model.
    // hold=0 drops enable right after the start edge; hold=1 keeps it until (drop_fr, drop_o).
    task automatic run_frames(input string tag, input int hs, input int vsz, input int nfr,
                              input int pat, input int f0, input int hold,
                              input int drop_fr, input int drop_o, input int new_pat);
        int flen, llen, a, x, y;
        logic [7:0] f, ed;
        logic eh;
        llen = hs + 3;
        flen = 2 + 5 + hs * vsz + (vsz - 1) * 3 + 4;
        enable = 1'b1;
        pattern_sel = 2'(pat);
        step();
        check({tag, "_lat_vsync"}, {31'd0, mon_vs}, 32'd0);
        check({tag, "_lat_busy"},  {31'd0, mon_bz}, 32'd0);
        if (hold == 0) enable = 1'b0;
        for (int fr = 0; fr < nfr; fr++) begin
            f = 8'(f0 + fr);
            for (int o = 0; o < flen; o++) begin
                step();
                a  = o - 7;
                eh = (a >= 0) && (a < vsz * llen - 3) && ((a % llen) < hs);
                x  = (a >= 0) ? (a % llen) : 0;
                y  = (a >= 0) ? (a / llen) : 0;
                ed = 8'h00;
                if (eh) begin
                    case (pat)
                        0: ed = 8'(x);
                        1: ed = 8'(y);
                        2: ed = ((x / 16) % 2 != (y / 16) % 2) ? 8'hFF : 8'h00;
                        default: ed = 8'(x + y + int'(f));
                    endcase
                end
                check({tag, "_vsync"}, {31'd0, mon_vs}, {31'd0, (o < 2)});
                check({tag, "_href"},  {31'd0, mon_hr}, {31'd0, eh});
                check({tag, "_data"},  {24'd0, mon_dt}, {24'd0, ed});
                check({tag, "_busy"},  {31'd0, mon_bz}, 32'd1);
                check({tag, "_fcnt"},  {24'd0, mon_fc}, {24'd0, f});
                if (hold != 0 && fr == drop_fr && o == drop_o) begin
                    enable = 1'b0;
                    pattern_sel = 2'(new_pat);
                end
            end
        end
        step();
        check_idle({tag, "_end"}, 8'(f0 + nfr));
        step();
        check_idle({tag, "_end2"}, 8'(f0 + nfr));
    endtask

    initial begin
        rst = 1'b0;
        enable = 1'b0;
        pattern_sel = 2'd0;
        sel_b = 1'b0;

        // Reset state
        do_reset();
        check_idle("reset", 8'd0);

        // Single frame, horizontal ramp
        run_frames("single", 8, 4, 1, 0, 0, 0, 0, 0, 0);

        // Back-to-back diagonal ramp: first pixels 00,01,02; frame 2 line 3 last pixel 0C
        do_reset();
        run_frames("b2b", 8, 4, 3, 3, 0, 1, 2, 20, 3);

        // Enable drop during line 2 with a pattern change: frame finishes with pattern 1
        run_frames("drop", 8, 4, 1, 1, 3, 1, 0, 30, 0);

        // Reset during an active line at x=3
        enable = 1'b1;
        pattern_sel = 2'd0;
        step();
        enable = 1'b0;
        repeat (11) step();
        check("midline_href", {31'd0, mon_hr}, 32'd1);
        check("midline_data", {24'd0, mon_dt}, 32'd3);
        rst = 1'b1;
        step();
        check_idle("rst_mid", 8'd0);
        rst = 1'b0;
        step();
        check_idle("rst_mid2", 8'd0);
        run_frames("after_rst", 8, 4, 1, 0, 0, 0, 0, 0, 0);

        // frame_cnt wraps after 256 frames
        do_reset();
        run_frames("wrap", 8, 4, 256, 3, 0, 1, 255, 10, 3);

        // 16x16 checker on the 32x32 instance
        do_reset();
        sel_b = 1'b1;
        run_frames("checker", 32, 32, 1, 2, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
